ps2_tx_frame_shifter: RTL and testbench
=======================================

PS2_TX_FRAME_SHIFTER -- requirements
Module: ps2_tx_frame_shifter

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning the payload width (range 5..16).
REQ-002 The block SHALL have parameter PARITY_EN, default 1, meaning a parity bit is appended after the data when 1.
REQ-003 The block SHALL have parameter PARITY_ODD, default 1, meaning odd parity when 1 and even parity when 0.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, meaning the number of stop bits (1..2).
REQ-005 The block SHALL have parameter ACK_EN, default 1, meaning one acknowledge bit is sampled after the stop bits when 1.
REQ-006 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning the maximum clocks allowed between ShiftEn strobes while busy (0 disables the timeout).
REQ-007 The block SHALL have port Clk, input, 1, meaning the single clock (all logic on its rising edge).
REQ-008 The block SHALL have port nReset, input, 1, meaning reset that is synchronous and active-low.
REQ-009 The block SHALL have port Load, input, 1, meaning a request to start a frame with Data.
REQ-010 The block SHALL have port Data, input, DATA_BITS, meaning the payload captured on an accepted Load.
REQ-011 The block SHALL have port ShiftEn, input, 1, meaning a one-Clk strobe per PS/2 bit slot, already synchronised to Clk.
REQ-012 The block SHALL have port AckIn, input, 1, meaning the synchronised line level sampled in the acknowledge slot.
REQ-013 The block SHALL have port Abort, input, 1, meaning a synchronous cancel of any frame in progress.
REQ-014 The block SHALL have port Q, output, 1, meaning the serial data to drive onto the line (1 = released).
REQ-015 The block SHALL have port Ready, output, 1, meaning Load will be accepted this cycle.
REQ-016 The block SHALL have port Busy, output, 1, meaning a frame is in progress.
REQ-017 The block SHALL have port Done, output, 1, meaning a one-cycle pulse at the end of a frame.
REQ-018 The block SHALL have ports AckErr and TimeoutErr, output, 1 each, meaning the status of the last frame, valid with Done.

Function
REQ-019 The frame SHALL be FRAME_BITS = 1 + DATA_BITS + PARITY_EN + STOP_BITS bits long: start 0, Data LSB first, parity, stop 1(s).
REQ-020 The parity bit SHALL make the count of ones over Data plus parity odd when PARITY_ODD=1 and even otherwise.
REQ-021 The FSM SHALL have states IDLE, SHIFT and ACK; Ready = IDLE; Busy = SHIFT or ACK.
REQ-022 In IDLE, Load=1 and Abort=0 SHALL latch the frame, clear the bit index, AckErr and TimeoutErr, and enter SHIFT; Q = start bit (0) from the next cycle.
REQ-023 Load SHALL be ignored while Busy, with no effect on the frame.
REQ-024 In SHIFT, each ShiftEn SHALL advance the index by one; Q SHALL always equal the frame bit at the current index.
REQ-025 A ShiftEn at index FRAME_BITS-1 SHALL enter ACK if ACK_EN=1, and otherwise enter IDLE with Done pulsed in the first IDLE cycle.
REQ-026 In ACK, Q SHALL be 1; the next ShiftEn SHALL sample AckIn, set AckErr = AckIn (a correct acknowledge is 0), enter IDLE and pulse Done.
REQ-027 The timeout counter SHALL clear on Load and on every ShiftEn while Busy; if it reaches TIMEOUT_CYCLES, the block SHALL set TimeoutErr, enter IDLE and pulse Done.
REQ-028 Abort SHALL take priority over Load, ShiftEn and timeout: it enters IDLE, sets Q=1 and leaves error flags unchanged, and no Done pulse is produced.
REQ-029 ShiftEn in IDLE SHALL have no effect.
REQ-030 Load in the Done cycle (IDLE) SHALL be accepted, allowing back-to-back frames.
REQ-031 AckErr and TimeoutErr SHALL hold their values until the next accepted Load or reset.

Reset
REQ-032 When nReset=0 at a rising edge of Clk, the block SHALL enter IDLE with Q=1, Ready=1, Busy=0, Done=0, AckErr=0, TimeoutErr=0, and the index and timeout counter at 0; this applies also in the middle of a frame.

Verification
REQ-033 Defaults, Data=8'hA5, Load, 11 ShiftEn -> Q sequence 0,1,0,1,0,0,1,0,1,1,1; then AckIn=0 plus ShiftEn -> Done pulse, AckErr=0.
REQ-034 Defaults, Data=8'h00, AckIn=1 in the ACK slot -> parity bit 1, Done pulse, AckErr=1 held until the next Load.
REQ-035 TIMEOUT_CYCLES=16, Load, then no ShiftEn -> TimeoutErr=1 and Done pulse 16 clocks after the last clear; Q=1, Ready=1.
REQ-036 Abort issued at index 4 together with ShiftEn -> IDLE next cycle, Q=1, no Done; a second Load during the frame before that is ignored.
REQ-037 DATA_BITS=9, PARITY_ODD=0, STOP_BITS=2, ACK_EN=0 -> frame length 13; Done pulses after the 13th ShiftEn; Load in the Done cycle starts the next frame.
REQ-038 nReset=0 asserted in ACK -> all outputs at reset values on the next cycle; the following Load behaves normally.

Source files
------------

// File: rtl/ps2_tx_frame_shifter.sv
// PS/2 host-to-device frame shifter.
// Builds the frame from the payload: start bit, data LSB first, optional parity,
// stop bit(s). One bit is presented on Q for each ShiftEn slot. An optional
// acknowledge slot follows the frame, and a watchdog ends a frame whose strobes
// stop arriving.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line released (Q=1), Ready asserted, Done pulses here for one cycle
// SHIFT | frame bits driven on Q, one per ShiftEn
// ACK   | line released, next ShiftEn samples AckIn as the device acknowledge
module ps2_tx_frame_shifter #(
  parameter int DATA_BITS      = 8,
  parameter int PARITY_EN      = 1,
  parameter int PARITY_ODD     = 1,
  parameter int STOP_BITS      = 1,
  parameter int ACK_EN         = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 Clk,
  input  logic                 nReset,
  input  logic                 Load,
  input  logic [DATA_BITS-1:0] Data,
  input  logic                 ShiftEn,
  input  logic                 AckIn,
  input  logic                 Abort,
  output logic                 Q,
  output logic                 Ready,
  output logic                 Busy,
  output logic                 Done,
  output logic                 AckErr,
  output logic                 TimeoutErr
);

  localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_EN + STOP_BITS;
  // The start bit is always 0, so only the bits after it are stored.
  localparam int TAIL_BITS  = FRAME_BITS - 1;
  localparam int IDX_W      = $clog2(FRAME_BITS);
  localparam int TMO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TMO_EN   = (TIMEOUT_CYCLES > 0);
  localparam bit ACK_SLOT = (ACK_EN != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t               state;
  logic [TAIL_BITS-1:0] tail_r;
  logic [TAIL_BITS-1:0] tail_load;
  logic [IDX_W-1:0]     bit_idx;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 parity_bit;
  logic                 tmo_hit;

  assign Ready   = (state == IDLE);
  assign Busy    = (state == SHIFT) || (state == ACK);
  // The watchdog fires on the clock that would bring the count to TIMEOUT_CYCLES.
  assign tmo_hit = TMO_EN && (tmo_cnt == TMO_LAST);

  // Assemble the post-start part of the frame: data, parity, stop ones.
  always_comb begin
    parity_bit = (PARITY_ODD != 0) ? ~(^Data) : (^Data);
    tail_load = '1;
    tail_load[DATA_BITS-1:0] = Data;
    if (PARITY_EN != 0) tail_load[DATA_BITS] = parity_bit;
  end

  // Frame sequencer: Abort beats ShiftEn, and ShiftEn beats the watchdog.
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state      <= IDLE;
      tail_r     <= '1;
      bit_idx    <= '0;
      tmo_cnt    <= '0;
      Q          <= 1'b1;
      Done       <= 1'b0;
      AckErr     <= 1'b0;
      TimeoutErr <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (Abort) begin
        state   <= IDLE;
        Q       <= 1'b1;
        bit_idx <= '0;
        tmo_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (Load) begin
              tail_r     <= tail_load;
              bit_idx    <= '0;
              tmo_cnt    <= '0;
              AckErr     <= 1'b0;
              TimeoutErr <= 1'b0;
              Q          <= 1'b0;
              state      <= SHIFT;
            end
          end
          SHIFT: begin
            if (ShiftEn) begin
              tmo_cnt <= '0;
              if (bit_idx == IDX_LAST) begin
                Q       <= 1'b1;
                bit_idx <= '0;
                if (ACK_SLOT) begin
                  state <= ACK;
                end else begin
                  state <= IDLE;
                  Done  <= 1'b1;
                end
              end else begin
                bit_idx <= bit_idx + IDX_W'(1);
                Q       <= tail_r[0];
                tail_r  <= {1'b1, tail_r[TAIL_BITS-1:1]};
              end
            end else if (tmo_hit) begin
              state      <= IDLE;
              Q          <= 1'b1;
              bit_idx    <= '0;
              tmo_cnt    <= '0;
              TimeoutErr <= 1'b1;
              Done       <= 1'b1;
            end else if (TMO_EN) begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
          ACK: begin
            if (ShiftEn) begin
              AckErr  <= AckIn;
              state   <= IDLE;
              tmo_cnt <= '0;
              Done    <= 1'b1;
            end else if (tmo_hit) begin
              state      <= IDLE;
              tmo_cnt    <= '0;
              TimeoutErr <= 1'b1;
              Done       <= 1'b1;
            end else if (TMO_EN) begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            Q     <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_tx_frame_shifter.sv
// Directed bench for ps2_tx_frame_shifter: default build (a), short watchdog (b),
// and a 9-bit even-parity, two-stop, no-acknowledge build (c) on shared stimulus.
module tb_ps2_tx_frame_shifter;

  logic       Clk;
  logic       nReset;
  logic       Load;
  logic [7:0] data_a;
  logic [8:0] data_c;
  logic       ShiftEn;
  logic       AckIn;
  logic       Abort;

  logic q_a, ready_a, busy_a, done_a, ack_err_a, tmo_err_a;
  logic q_b, ready_b, busy_b, done_b, ack_err_b, tmo_err_b;
  logic q_c, ready_c, busy_c, done_c, ack_err_c, tmo_err_c;

  int n_checks = 0;
  int n_errors = 0;

  logic [10:0] exp_a;
  logic [12:0] exp_c;

  ps2_tx_frame_shifter u_dut_a (
    .Clk(Clk), .nReset(nReset), .Load(Load), .Data(data_a), .ShiftEn(ShiftEn),
    .AckIn(AckIn), .Abort(Abort), .Q(q_a), .Ready(ready_a), .Busy(busy_a),
    .Done(done_a), .AckErr(ack_err_a), .TimeoutErr(tmo_err_a)
  );

  ps2_tx_frame_shifter #(.TIMEOUT_CYCLES(16)) u_dut_b (
    .Clk(Clk), .nReset(nReset), .Load(Load), .Data(data_a), .ShiftEn(ShiftEn),
    .AckIn(AckIn), .Abort(Abort), .Q(q_b), .Ready(ready_b), .Busy(busy_b),
    .Done(done_b), .AckErr(ack_err_b), .TimeoutErr(tmo_err_b)
  );

  ps2_tx_frame_shifter #(.DATA_BITS(9), .PARITY_ODD(0), .STOP_BITS(2), .ACK_EN(0)) u_dut_c (
    .Clk(Clk), .nReset(nReset), .Load(Load), .Data(data_c), .ShiftEn(ShiftEn),
    .AckIn(AckIn), .Abort(Abort), .Q(q_c), .Ready(ready_c), .Busy(busy_c),
    .Done(done_c), .AckErr(ack_err_c), .TimeoutErr(tmo_err_c)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic strobe();
    ShiftEn = 1'b1;
    tick();
    ShiftEn = 1'b0;
  endtask

  task automatic load_frame();
    Load = 1'b1;
    tick();
    Load = 1'b0;
  endtask

  task automatic do_reset();
    nReset  = 1'b0;
    Load    = 1'b0;
    ShiftEn = 1'b0;
    AckIn   = 1'b0;
    Abort   = 1'b0;
    tick();
    tick();
    nReset = 1'b1;
  endtask

  initial begin
    data_a = 8'h00;
    data_c = 9'h000;
    do_reset();

    // reset state
    check_eq("rst_q", q_a, 1'b1);
    check_eq("rst_ready", ready_a, 1'b1);
    check_eq("rst_busy", busy_a, 1'b0);
    check_eq("rst_done", done_a, 1'b0);
    check_eq("rst_ackerr", ack_err_a, 1'b0);
    check_eq("rst_tmoerr", tmo_err_a, 1'b0);

    // A5 frame with good acknowledge
    data_a = 8'hA5;
    load_frame();
    check_eq("a5_busy", busy_a, 1'b1);
    check_eq("a5_ready", ready_a, 1'b0);
    exp_a = 11'b11101001010;
    for (int i = 0; i < 11; i++) begin
      check_eq($sformatf("a5_q%0d", i), q_a, exp_a[i]);
      strobe();
    end
    check_eq("a5_ack_q", q_a, 1'b1);
    check_eq("a5_ack_busy", busy_a, 1'b1);
    check_eq("a5_ack_nodone", done_a, 1'b0);
    AckIn = 1'b0;
    strobe();
    check_eq("a5_done", done_a, 1'b1);
    check_eq("a5_ackerr", ack_err_a, 1'b0);
    check_eq("a5_ready_end", ready_a, 1'b1);
    tick();
    check_eq("a5_done_pulse", done_a, 1'b0);

    // 00 frame, parity 1, missing acknowledge
    do_reset();
    data_a = 8'h00;
    load_frame();
    exp_a = 11'b11000000000;
    for (int i = 0; i < 11; i++) begin
      check_eq($sformatf("z_q%0d", i), q_a, exp_a[i]);
      strobe();
    end
    AckIn = 1'b1;
    strobe();
    AckIn = 1'b0;
    check_eq("z_done", done_a, 1'b1);
    check_eq("z_ackerr", ack_err_a, 1'b1);
    tick();
    tick();
    tick();
    check_eq("z_ackerr_hold", ack_err_a, 1'b1);
    check_eq("z_done_low", done_a, 1'b0);
    data_a = 8'hA5;
    load_frame();
    check_eq("z_ackerr_clr", ack_err_a, 1'b0);

    // watchdog: 16 clocks after the last ShiftEn
    do_reset();
    data_a = 8'h5A;
    load_frame();
    repeat (5) tick();
    strobe();
    for (int k = 1; k <= 15; k++) tick();
    check_eq("tmo_nodone15", done_b, 1'b0);
    check_eq("tmo_busy15", busy_b, 1'b1);
    tick();
    check_eq("tmo_done", done_b, 1'b1);
    check_eq("tmo_err", tmo_err_b, 1'b1);
    check_eq("tmo_q", q_b, 1'b1);
    check_eq("tmo_ready", ready_b, 1'b1);
    check_eq("tmo_ackerr", ack_err_b, 1'b0);
    tick();
    check_eq("tmo_done_pulse", done_b, 1'b0);
    check_eq("tmo_err_hold", tmo_err_b, 1'b1);

    // ignored reload mid-frame, then abort at index 4
    do_reset();
    data_a = 8'hA5;
    load_frame();
    strobe();
    strobe();
    data_a = 8'hFF;
    load_frame();
    check_eq("ab_q2", q_a, 1'b0);
    strobe();
    check_eq("ab_q3", q_a, 1'b1);
    strobe();
    check_eq("ab_q4", q_a, 1'b0);
    Abort   = 1'b1;
    ShiftEn = 1'b1;
    tick();
    Abort   = 1'b0;
    ShiftEn = 1'b0;
    check_eq("ab_ready", ready_a, 1'b1);
    check_eq("ab_busy", busy_a, 1'b0);
    check_eq("ab_q", q_a, 1'b1);
    check_eq("ab_nodone", done_a, 1'b0);
    tick();
    check_eq("ab_nodone2", done_a, 1'b0);
    strobe();
    check_eq("idle_shift_q", q_a, 1'b1);
    check_eq("idle_shift_ready", ready_a, 1'b1);
    check_eq("idle_shift_done", done_a, 1'b0);

    // 9-bit even parity, two stops, no acknowledge, back-to-back frames
    do_reset();
    data_c = 9'h1A5;
    load_frame();
    exp_c = 13'b1111101001010;
    for (int i = 0; i < 13; i++) begin
      check_eq($sformatf("c1_q%0d", i), q_c, exp_c[i]);
      if (i == 12) check_eq("c1_nodone12", done_c, 1'b0);
      strobe();
    end
    check_eq("c1_done", done_c, 1'b1);
    check_eq("c1_ready", ready_c, 1'b1);
    check_eq("c1_ackerr", ack_err_c, 1'b0);
    check_eq("c1_tmoerr", tmo_err_c, 1'b0);
    data_c = 9'h003;
    load_frame();
    check_eq("c2_busy", busy_c, 1'b1);
    check_eq("c2_done_low", done_c, 1'b0);
    exp_c = 13'b1100000000110;
    for (int i = 0; i < 13; i++) begin
      check_eq($sformatf("c2_q%0d", i), q_c, exp_c[i]);
      strobe();
    end
    check_eq("c2_done", done_c, 1'b1);

    // reset while waiting for the acknowledge
    do_reset();
    data_a = 8'h3C;
    load_frame();
    repeat (11) strobe();
    check_eq("ra_busy", busy_a, 1'b1);
    nReset = 1'b0;
    tick();
    check_eq("ra_q", q_a, 1'b1);
    check_eq("ra_ready", ready_a, 1'b1);
    check_eq("ra_busy0", busy_a, 1'b0);
    check_eq("ra_done", done_a, 1'b0);
    check_eq("ra_ackerr", ack_err_a, 1'b0);
    check_eq("ra_tmoerr", tmo_err_a, 1'b0);
    nReset = 1'b1;
    data_a = 8'h01;
    load_frame();
    check_eq("ra2_q0", q_a, 1'b0);
    strobe();
    check_eq("ra2_q1", q_a, 1'b1);
    repeat (10) strobe();
    AckIn = 1'b0;
    strobe();
    check_eq("ra2_done", done_a, 1'b1);
    check_eq("ra2_ackerr", ack_err_a, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
